// File: rtl/adc_avg_bcd_if.sv
// Voltmeter averaging/BCD stage bus: trigger, received frames and display results.
interface adc_avg_bcd_if #(
  parameter int BITS = 16
);
  logic            run;
  logic            adc_start;
  logic [BITS-1:0] din;
  logic            din_vld;
  logic [13:0]     mv;
  logic [15:0]     bcd;
  logic            out_vld;
  logic            busy;
  logic            ovr;

  modport master (
    output run, din, din_vld,
    input  adc_start, mv, bcd, out_vld, busy, ovr
  );

  modport slave (
    input  run, din, din_vld,
    output adc_start, mv, bcd, out_vld, busy, ovr
  );
endinterface

// File: rtl/adc_avg_bcd.sv
// Conversion trigger, 2**LOG2_AVG sample averager, mV scaling and sequential
// double-dabble BCD conversion for the voltmeter display path.
module adc_avg_bcd #(
  parameter int BITS     = 16,
  parameter int SAMPLE_W = 12,
  parameter int LOG2_AVG = 4,
  parameter int VREF_MV  = 3300,
  parameter int PERIOD   = 100000
) (
  input logic         clk,
  input logic         rst,
  adc_avg_bcd_if.slave bus
);
  localparam int MV_W   = 14;
  localparam int BCD_W  = 16;
  localparam int DD_W   = BCD_W + MV_W;
  localparam int ACC_W  = SAMPLE_W + LOG2_AVG;
  localparam int PROD_W = SAMPLE_W + MV_W;
  localparam int TRIG_W = $clog2(PERIOD);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_CONV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [TRIG_W-1:0]   trig_q, trig_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_AVG-1:0] smp_q, smp_d;
  logic [SAMPLE_W-1:0] avg_q, avg_d;
  logic [1:0]          state_q, state_d;
  logic [3:0]          it_q, it_d;
  logic [MV_W-1:0]     mvr_q, mvr_d;
  logic [DD_W-1:0]     dd_q, dd_d;
  logic [MV_W-1:0]     mv_q, mv_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                ovr_q, ovr_d;

  logic [BITS-1:0]     frame;
  logic [SAMPLE_W-1:0] sample;
  logic [ACC_W-1:0]    acc_sum;
  logic                win_done;
  logic                trig_wrap;
  logic [PROD_W-1:0]   prod;
  logic [DD_W-1:0]     dd_adj;
  logic [DD_W-1:0]     dd_shift;

  assign frame     = bus.din;
  assign sample    = SAMPLE_W'(frame);
  assign acc_sum   = acc_q + ACC_W'(sample);
  assign win_done  = bus.din_vld && (smp_q == '1);
  assign trig_wrap = (trig_q == TRIG_W'(PERIOD - 1));
  assign prod      = PROD_W'(avg_q) * PROD_W'(VREF_MV);

  // Double-dabble step: bias every BCD digit >= 5 by 3, then shift the whole
  // {bcd, binary} register left by one.
  always_comb begin
    dd_adj = dd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (dd_q[MV_W + 4*i +: 4] >= 4'd5)
        dd_adj[MV_W + 4*i +: 4] = dd_q[MV_W + 4*i +: 4] + 4'd3;
    end
  end
  assign dd_shift = {dd_adj[DD_W-2:0], 1'b0};

  always_comb begin
    trig_d  = (!bus.run || trig_wrap) ? '0 : trig_q + 1'b1;
    acc_d   = acc_q;
    smp_d   = smp_q;
    avg_d   = avg_q;
    state_d = state_q;
    it_d    = it_q;
    mvr_d   = mvr_q;
    dd_d    = dd_q;
    mv_d    = mv_q;
    bcd_d   = bcd_q;
    ovr_d   = ovr_q;

    if (bus.din_vld) begin
      if (win_done) begin
        acc_d = '0;
        smp_d = '0;
        // The average is only captured when the converter can take it.
        if (state_q == S_IDLE) avg_d = acc_sum[ACC_W-1:LOG2_AVG];
        else                   ovr_d = 1'b1;
      end else begin
        acc_d = acc_sum;
        smp_d = smp_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: if (win_done) state_d = S_MUL;
      S_MUL: begin
        mvr_d   = prod[SAMPLE_W +: MV_W];
        dd_d    = {{BCD_W{1'b0}}, prod[SAMPLE_W +: MV_W]};
        it_d    = '0;
        state_d = S_CONV;
      end
      S_CONV: begin
        dd_d = dd_shift;
        it_d = it_q + 1'b1;
        if (it_q == 4'(MV_W - 1)) begin
          state_d = S_DONE;
          mv_d    = mvr_q;
          bcd_d   = dd_shift[DD_W-1 -: BCD_W];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_q  <= '0;
      acc_q   <= '0;
      smp_q   <= '0;
      avg_q   <= '0;
      state_q <= S_IDLE;
      it_q    <= '0;
      mvr_q   <= '0;
      dd_q    <= '0;
      mv_q    <= '0;
      bcd_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      trig_q  <= trig_d;
      acc_q   <= acc_d;
      smp_q   <= smp_d;
      avg_q   <= avg_d;
      state_q <= state_d;
      it_q    <= it_d;
      mvr_q   <= mvr_d;
      dd_q    <= dd_d;
      mv_q    <= mv_d;
      bcd_q   <= bcd_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.adc_start = bus.run & trig_wrap;
  assign bus.mv        = mv_q;
  assign bus.bcd       = bcd_q;
  assign bus.out_vld   = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_MUL) || (state_q == S_CONV);
  assign bus.ovr       = ovr_q;
endmodule

// File: tb/tb_adc_avg_bcd.sv
// Self-checking bench for adc_avg_bcd: table of averaging windows with a
// result scoreboard, plus trigger, overrun and mid-conversion reset sequences.
module tb_adc_avg_bcd;
  localparam int PERIOD = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adc_avg_bcd_if #(.BITS(16)) bus ();

  adc_avg_bcd #(
    .BITS(16), .SAMPLE_W(12), .LOG2_AVG(4), .VREF_MV(3300), .PERIOD(PERIOD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [13:0] mv;
    logic [15:0] bcd;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          gap;
    logic [13:0] mv;
    logic [15:0] bcd;
  } vec_t;

  exp_t sbq[$];
  int   pulses[$];
  int   cyc        = 0;
  int   errors     = 0;
  int   checks     = 0;
  int   model_done = -1;
  int   last_cmp   = 0;
  int   out_cnt    = 0;
  bit   chk_busy   = 1'b0;
  bit   trig_mon   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h (%0d), expected 0x%0h (%0d)",
               name, cyc, act, act, exp, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic bit model_busy(input int c);
    return (model_done >= 0) && (c >= model_done - 15) && (c <= model_done - 1);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (chk_busy) check("busy", 32'(bus.busy), 32'(model_busy(cyc)));
    if (trig_mon && bus.adc_start === 1'b1) pulses.push_back(cyc);
    if (bus.out_vld === 1'b1) begin
      out_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_vld at cycle %0d: mv=%0d bcd=0x%0h, expected no strobe",
                 cyc, bus.mv, bus.bcd);
      end else begin
        e = sbq.pop_front();
        check("mv", 32'(bus.mv), 32'(e.mv));
        check("bcd", 32'(bus.bcd), 32'(e.bcd));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Registers the completing strobe (cycle c) with the scoreboard.
  task automatic complete(input int sum, input int c, input bit use_exp,
                          input logic [13:0] emv, input logic [15:0] ebcd);
    exp_t e;
    int avg, mvm;
    avg = sum / 16;
    mvm = (avg * 3300) / 4096;
    e.mv  = use_exp ? emv : 14'(mvm);
    e.bcd = use_exp ? ebcd : to_bcd(mvm);
    e.cyc = c + 16;
    last_cmp = c;
    if (c > model_done) begin
      sbq.push_back(e);
      model_done = c + 16;
    end
  endtask

  task automatic send_window(input logic [15:0] a, input logic [15:0] b, input int gap,
                             input bit use_exp, input logic [13:0] emv, input logic [15:0] ebcd);
    int sum;
    logic [15:0] d;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap && i > 0; g++) begin
        @(posedge clk); #1;
        bus.din_vld = 1'b0;
        bus.din     = 16'hFFFF;
      end
      @(posedge clk); #1;
      d = (i < 8) ? a : b;
      bus.din     = d;
      bus.din_vld = 1'b1;
      sum += int'(d[11:0]);
      if (i == 15) complete(sum, cyc, use_exp, emv, ebcd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.din_vld = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(sbq.size()), 32'd0);
  endtask

  vec_t vt[7];
  int rel, m, oc;
  logic [15:0] ra, rb;

  initial begin
    bus.run     = 1'b0;
    bus.din     = '0;
    bus.din_vld = 1'b0;

    vt[0] = '{16'h0FFF, 16'h0FFF, 0, 14'd3299, 16'h3299};
    vt[1] = '{16'hF800, 16'hF800, 1, 14'd1650, 16'h1650};
    vt[2] = '{16'h0000, 16'h07FF, 0, 14'd824,  16'h0824};
    vt[3] = '{16'h0000, 16'h0000, 2, 14'd0,    16'h0000};
    vt[4] = '{16'h0ABC, 16'h0ABC, 0, 14'd2213, 16'h2213};
    vt[5] = '{16'h0400, 16'h0400, 3, 14'd825,  16'h0825};
    vt[6] = '{16'h1FFE, 16'h1FFE, 0, 14'd3298, 16'h3298};

    repeat (3) @(posedge clk);
    #1;
    check("rst_mv", 32'(bus.mv), 32'd0);
    check("rst_bcd", 32'(bus.bcd), 32'd0);
    check("rst_out_vld", 32'(bus.out_vld), 32'd0);
    check("rst_ovr", 32'(bus.ovr), 32'd0);
    check("rst_adc_start", 32'(bus.adc_start), 32'd0);

    // Trigger: release reset with run already high.
    rst      = 1'b1;
    bus.run  = 1'b1;
    rel      = cyc;
    chk_busy = 1'b1;
    trig_mon = 1'b1;
    repeat (30) @(posedge clk);
    check("trig_pulse_count", 32'(pulses.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < pulses.size()) check("trig_pulse_cycle", 32'(pulses[i] - rel), 32'(9 + 10*i));
    repeat (4) @(posedge clk);
    #1;
    bus.run = 1'b0;
    pulses.delete();
    repeat (25) @(posedge clk);
    check("trig_off_pulses", 32'(pulses.size()), 32'd0);
    #1;
    bus.run = 1'b1;
    m = cyc;
    repeat (12) @(posedge clk);
    check("trig_restart_count", 32'(pulses.size()), 32'd1);
    if (pulses.size() > 0) check("trig_restart_cycle", 32'(pulses[0] - m), 32'd9);
    trig_mon = 1'b0;

    // Table of windows; run stays high so triggers overlap strobes freely.
    foreach (vt[i]) begin
      send_window(vt[i].a, vt[i].b, vt[i].gap, 1'b1, vt[i].mv, vt[i].bcd);
      idle(1);
      wait_drain("table_drain");
      idle(2);
    end
    repeat (10) @(posedge clk);
    check("hold_mv", 32'(bus.mv), 32'd3298);
    check("hold_bcd", 32'(bus.bcd), 32'h3298);

    for (int i = 0; i < 2; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      send_window(ra, rb, i, 1'b0, '0, '0);
      idle(1);
      wait_drain("random_drain");
    end

    // Window completing one cycle after DONE is accepted.
    check("ovr_before", 32'(bus.ovr), 32'd0);
    send_window(16'h0800, 16'h0800, 0, 1'b1, 14'd1650, 16'h1650);
    idle(1);
    send_window(16'h0FFF, 16'h0FFF, 0, 1'b1, 14'd3299, 16'h3299);
    idle(1);
    wait_drain("after_done_drain");
    check("ovr_after_done", 32'(bus.ovr), 32'd0);

    // Window completing in the DONE cycle is discarded and sets ovr.
    oc = out_cnt;
    send_window(16'h0400, 16'h0400, 0, 1'b1, 14'd825, 16'h0825);
    send_window(16'h0FFF, 16'h0FFF, 0, 1'b1, 14'd3299, 16'h3299);
    idle(1);
    wait_drain("ovr_drain");
    repeat (20) @(posedge clk);
    check("ovr_set", 32'(bus.ovr), 32'd1);
    check("ovr_single_out", 32'(out_cnt - oc), 32'd1);
    check("ovr_mv_first", 32'(bus.mv), 32'd825);

    // Reset during CONV abandons the conversion.
    send_window(16'h0ABC, 16'h0ABC, 0, 1'b1, 14'd2213, 16'h2213);
    idle(1);
    while (cyc < last_cmp + 8) @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    model_done = -1;
    oc = out_cnt;
    #1;
    check("rstconv_mv", 32'(bus.mv), 32'd0);
    check("rstconv_bcd", 32'(bus.bcd), 32'd0);
    check("rstconv_out_vld", 32'(bus.out_vld), 32'd0);
    check("rstconv_ovr", 32'(bus.ovr), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    check("rstconv_no_out", 32'(out_cnt - oc), 32'd0);
    send_window(16'h0ABC, 16'h0ABC, 0, 1'b1, 14'd2213, 16'h2213);
    idle(1);
    wait_drain("fresh_drain");
    repeat (3) @(posedge clk);
    check("fresh_mv", 32'(bus.mv), 32'd2213);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
